// File: rtl/dma_ahb_pkg.sv
// rtl/dma_ahb_pkg.sv - AHB encodings and FSM state type shared by the DMA AHB master
package dma_ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HBURST_INCR = 3'b001;
    localparam logic [2:0] HSIZE_WORD  = 3'b010;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;
    localparam logic [1:0] HRESP_RETRY = 2'b10;
    localparam logic [1:0] HRESP_SPLIT = 2'b11;

    localparam int MAX_BEATS = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARB,
        ST_XFER,
        ST_LAST,
        ST_DONE
    } state_t;

endpackage

// File: rtl/dma_beat_ctr.sv
// rtl/dma_beat_ctr.sv - burst address register and remaining-beat counter
module dma_beat_ctr
    import dma_ahb_pkg::*;
#(
    parameter int AW = 32,
    parameter int BW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [AW-1:0] load_addr,
    input  logic [BW-1:0] load_beats,
    input  logic          step,
    input  logic          rewind,
    output logic [AW-1:0] addr,
    output logic [AW-1:0] next_addr,
    output logic          boundary,
    output logic          last
);

    logic [BW-1:0] remaining;

    assign next_addr = addr + AW'(4);
    assign boundary  = (next_addr[9:0] == 10'd0);
    assign last      = (remaining == BW'(1));

    // addr always points at the next beat still to be accepted on the bus
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr      <= '0;
            remaining <= '0;
        end else if (load) begin
            addr      <= load_addr;
            remaining <= (load_beats == '0) ? BW'(MAX_BEATS) : load_beats;
        end else if (rewind) begin
            addr      <= addr - AW'(4);
            remaining <= remaining + BW'(1);
        end else if (step) begin
            addr      <= next_addr;
            remaining <= remaining - BW'(1);
        end
    end

endmodule

// File: rtl/dma_ahb_master.sv
// rtl/dma_ahb_master.sv - AHB INCR burst master servicing one DMA channel's read/write requests
module dma_ahb_master
    import dma_ahb_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32,
    parameter int BW = 5
) (
    input  logic          hclk,
    input  logic          hreset,
    input  logic          rd_req,
    input  logic          wr_req,
    input  logic [AW-1:0] rd_addr,
    input  logic [AW-1:0] wr_addr,
    input  logic [BW-1:0] beats,
    output logic          req_done,
    output logic          xfer_err,
    output logic          hbusreq,
    input  logic          hgrant,
    output logic [AW-1:0] haddr,
    output logic [1:0]    htrans,
    output logic          hwrite,
    output logic [2:0]    hsize,
    output logic [2:0]    hburst,
    output logic [DW-1:0] hwdata,
    input  logic [DW-1:0] hrdata,
    input  logic          hready,
    input  logic [1:0]    hresp,
    output logic          fifo_wr,
    output logic [DW-1:0] fifo_wdata,
    output logic          fifo_rd,
    input  logic [DW-1:0] fifo_rdata
);

    state_t        state;
    logic [1:0]    htrans_q;
    logic          dphase;
    logic          resume;
    logic          replay_v;
    logic [DW-1:0] replay_q;

    logic          accept;
    logic          resp_fail;
    logic          resp_retry;
    logic          ctr_load;
    logic [AW-1:0] ctr_load_addr;
    logic [AW-1:0] ctr_addr;
    logic [AW-1:0] ctr_next_addr;
    logic          ctr_boundary;
    logic          ctr_last;

    assign accept     = htrans_q[1] & hready;
    assign resp_fail  = dphase & ~hready & (hresp != HRESP_OKAY);
    assign resp_retry = resp_fail & ((hresp == HRESP_RETRY) | (hresp == HRESP_SPLIT));

    assign ctr_load      = (state == ST_IDLE) & (rd_req | wr_req);
    assign ctr_load_addr = wr_req ? wr_addr : rd_addr;

    dma_beat_ctr #(.AW(AW), .BW(BW)) u_beat_ctr (
        .clk        (hclk),
        .rst        (hreset),
        .load       (ctr_load),
        .load_addr  (ctr_load_addr),
        .load_beats (beats),
        .step       (accept),
        .rewind     (resp_retry),
        .addr       (ctr_addr),
        .next_addr  (ctr_next_addr),
        .boundary   (ctr_boundary),
        .last       (ctr_last)
    );

    // The pending address phase is cancelled in the first cycle of a two-cycle response
    assign htrans     = resp_fail ? HTRANS_IDLE : htrans_q;
    assign hsize      = HSIZE_WORD;
    assign hburst     = HBURST_INCR;
    assign fifo_rd    = accept & hwrite & ~replay_v;
    assign fifo_wr    = dphase & hready & ~hwrite & (hresp == HRESP_OKAY);
    assign fifo_wdata = fifo_wr ? hrdata : '0;

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            state    <= ST_IDLE;
            htrans_q <= HTRANS_IDLE;
            haddr    <= '0;
            hwrite   <= 1'b0;
            hbusreq  <= 1'b0;
            hwdata   <= '0;
            req_done <= 1'b0;
            xfer_err <= 1'b0;
            dphase   <= 1'b0;
            resume   <= 1'b0;
            replay_v <= 1'b0;
            replay_q <= '0;
        end else begin
            req_done <= 1'b0;

            if (resp_fail)
                dphase <= 1'b0;
            else if (hready)
                dphase <= accept;

            if (accept && hwrite) begin
                if (replay_v) begin
                    hwdata   <= replay_q;
                    replay_v <= 1'b0;
                end else begin
                    hwdata <= fifo_rdata;
                end
            end

            if (resp_fail) begin
                htrans_q <= HTRANS_IDLE;
                if (hresp == HRESP_ERROR) begin
                    xfer_err <= 1'b1;
                    hbusreq  <= 1'b0;
                    req_done <= 1'b1;
                    state    <= ST_DONE;
                end else begin
                    // hwdata still holds the word of the beat that must be re-issued
                    replay_v <= hwrite;
                    replay_q <= hwdata;
                    hbusreq  <= 1'b1;
                    state    <= ST_ARB;
                end
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (wr_req || rd_req) begin
                            hwrite   <= wr_req;
                            xfer_err <= 1'b0;
                            hbusreq  <= 1'b1;
                            replay_v <= 1'b0;
                            state    <= ST_ARB;
                        end
                    end
                    ST_ARB: begin
                        if (hgrant && hready) begin
                            htrans_q <= HTRANS_NONSEQ;
                            haddr    <= ctr_addr;
                            state    <= ST_XFER;
                        end
                    end
                    ST_XFER: begin
                        if (accept) begin
                            if (ctr_last) begin
                                htrans_q <= HTRANS_IDLE;
                                hbusreq  <= 1'b0;
                                resume   <= 1'b0;
                                state    <= ST_LAST;
                            end else if (!hgrant) begin
                                htrans_q <= HTRANS_IDLE;
                                resume   <= 1'b1;
                                state    <= ST_LAST;
                            end else begin
                                htrans_q <= ctr_boundary ? HTRANS_NONSEQ : HTRANS_SEQ;
                                haddr    <= ctr_next_addr;
                            end
                        end
                    end
                    ST_LAST: begin
                        if (dphase && hready) begin
                            if (resume) begin
                                state <= ST_ARB;
                            end else begin
                                req_done <= 1'b1;
                                state    <= ST_DONE;
                            end
                        end
                    end
                    ST_DONE: state <= ST_IDLE;
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_dma_ahb_master.sv
// tb/tb_dma_ahb_master.sv - directed bench for dma_ahb_master with a scripted AHB slave and FIFO model
module tb_dma_ahb_master;
    import dma_ahb_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = 5;

    logic          hclk = 1'b0;
    logic          hreset;
    logic          rd_req, wr_req;
    logic [AW-1:0] rd_addr, wr_addr;
    logic [BW-1:0] beats;
    logic          req_done, xfer_err, hbusreq, hgrant;
    logic [AW-1:0] haddr;
    logic [1:0]    htrans;
    logic          hwrite;
    logic [2:0]    hsize, hburst;
    logic [DW-1:0] hwdata, hrdata;
    logic          hready;
    logic [1:0]    hresp;
    logic          fifo_wr, fifo_rd;
    logic [DW-1:0] fifo_wdata, fifo_rdata;
    logic [31:0]   rptr = 32'd0;

    always #5 hclk = ~hclk;

    dma_ahb_master #(.AW(AW), .DW(DW), .BW(BW)) dut (
        .hclk       (hclk),
        .hreset     (hreset),
        .rd_req     (rd_req),
        .wr_req     (wr_req),
        .rd_addr    (rd_addr),
        .wr_addr    (wr_addr),
        .beats      (beats),
        .req_done   (req_done),
        .xfer_err   (xfer_err),
        .hbusreq    (hbusreq),
        .hgrant     (hgrant),
        .haddr      (haddr),
        .htrans     (htrans),
        .hwrite     (hwrite),
        .hsize      (hsize),
        .hburst     (hburst),
        .hwdata     (hwdata),
        .hrdata     (hrdata),
        .hready     (hready),
        .hresp      (hresp),
        .fifo_wr    (fifo_wr),
        .fifo_wdata (fifo_wdata),
        .fifo_rd    (fifo_rd),
        .fifo_rdata (fifo_rdata)
    );

    // show-ahead FIFO whose k-th word is D000_0000 + k
    assign fifo_rdata = 32'hD000_0000 + rptr;
    always @(posedge hclk) if (fifo_rd) rptr <= rptr + 32'd1;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc = 0;
    int n_acc, n_push, n_pop, n_wd, n_done, arb_cyc, done_cyc;
    int resp_stage, bad_beat, gnt_at, gnt_low;
    logic dp_active, acc_flag, waited, wait_mode;
    logic [1:0]  bad_resp, err_htrans;
    logic [1:0]  trans_log [0:31];
    logic [31:0] addr_log  [0:31];
    logic        hw_log    [0:31];
    logic [31:0] push_log  [0:31];
    logic [31:0] wd_log    [0:31];
    logic [31:0] rptr0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_log();
        n_acc = 0; n_push = 0; n_pop = 0; n_wd = 0; n_done = 0;
        arb_cyc = -1; done_cyc = -1;
        resp_stage = 0; bad_beat = 0; bad_resp = HRESP_OKAY;
        gnt_at = 0; gnt_low = 0; wait_mode = 1'b0; waited = 1'b0;
        err_htrans = 2'b11;
        rptr0 = rptr;
    endtask

    // observe at negedge, then play the slave for the next cycle just after posedge
    task automatic tick();
        @(negedge hclk);
        cyc++;
        if (hbusreq && arb_cyc < 0) arb_cyc = cyc;
        acc_flag = htrans[1] && hready;
        if (acc_flag && n_acc < 32) begin
            trans_log[n_acc] = htrans;
            addr_log[n_acc]  = haddr;
            hw_log[n_acc]    = hwrite;
        end
        if (acc_flag) n_acc++;
        if (fifo_wr && n_push < 32) push_log[n_push] = fifo_wdata;
        if (fifo_wr) n_push++;
        if (fifo_rd) n_pop++;
        if (dp_active && hready && hresp == HRESP_OKAY && hwrite && n_wd < 32) begin
            wd_log[n_wd] = hwdata;
            n_wd++;
        end
        if (dp_active && !hready && hresp != HRESP_OKAY) err_htrans = htrans;
        if (req_done) begin n_done++; done_cyc = cyc; end
        dp_active = acc_flag ? 1'b1 : (hready ? 1'b0 : dp_active);

        @(posedge hclk);
        #1;
        if (resp_stage == 1) begin
            hready = 1'b1; resp_stage = 0;
        end else if (dp_active) begin
            if (acc_flag && n_acc == bad_beat) begin
                hready = 1'b0; hresp = bad_resp; resp_stage = 1;
            end else if (wait_mode && !waited) begin
                hready = 1'b0; hresp = HRESP_OKAY; waited = 1'b1;
            end else begin
                hready = 1'b1; hresp = HRESP_OKAY; waited = 1'b0;
                hrdata = 32'hA000_0000 + n_acc;
            end
        end else begin
            hready = 1'b1; hresp = HRESP_OKAY;
        end
        if (gnt_low > 0) begin
            gnt_low--;
            if (gnt_low == 0) hgrant = 1'b1;
        end else if (gnt_at > 0 && acc_flag && n_acc == gnt_at) begin
            hgrant = 1'b0; gnt_low = 5; gnt_at = 0;
        end
    endtask

    task automatic run(input string tag);
        int d0;
        int k;
        d0 = n_done;
        k = 0;
        while (n_done == d0 && k < 300) begin tick(); k++; end
        chk(tag, 32'(n_done != d0), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        hreset = 1'b1; rd_req = 1'b0; wr_req = 1'b0;
        rd_addr = '0; wr_addr = '0; beats = '0;
        hgrant = 1'b1; hready = 1'b1; hresp = HRESP_OKAY; hrdata = '0;
        dp_active = 1'b0; acc_flag = 1'b0;
        clear_log();
        tick(); tick();
        chk("rst_htrans", 32'(htrans), 32'(HTRANS_IDLE));
        chk("rst_hbusreq", 32'(hbusreq), 32'd0);
        chk("rst_hsize", 32'(hsize), 32'h2);
        chk("rst_hburst", 32'(hburst), 32'h1);
        chk("rst_req_done", 32'(req_done), 32'd0);
        chk("rst_haddr", haddr, 32'd0);
        hreset = 1'b0;
        tick();

        // zero-wait read of 4 beats
        clear_log();
        rd_addr = 32'h1000; beats = 5'd4; rd_req = 1'b1;
        run("t1_done");
        rd_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("t1_htrans", 32'(trans_log[i]), (i == 0) ? 32'(HTRANS_NONSEQ) : 32'(HTRANS_SEQ));
            chk("t1_haddr", addr_log[i], 32'h1000 + 32'(4 * i));
            chk("t1_push", push_log[i], 32'hA000_0001 + 32'(i));
        end
        chk("t1_npush", 32'(n_push), 32'd4);
        chk("t1_latency", 32'(done_cyc - arb_cyc), 32'd6);
        chk("t1_xfer_err", 32'(xfer_err), 32'd0);
        tick(); tick(); tick();
        chk("t1_one_done", 32'(n_done), 32'd1);

        // 16-beat write with one wait state per beat
        clear_log();
        wait_mode = 1'b1;
        wr_addr = 32'h2000; beats = 5'd0; wr_req = 1'b1;
        run("t2_done");
        wr_req = 1'b0;
        tick(); tick(); tick();
        chk("t2_npop", 32'(n_pop), 32'd16);
        chk("t2_nacc", 32'(n_acc), 32'd16);
        chk("t2_nwd", 32'(n_wd), 32'd16);
        chk("t2_lastaddr", addr_log[15], 32'h203C);
        for (int i = 0; i < 16; i++)
            chk("t2_hwdata", wd_log[i], 32'hD000_0000 + rptr0 + 32'(i));
        chk("t2_one_done", 32'(n_done), 32'd1);

        // read across a 1 KB boundary
        clear_log();
        rd_addr = 32'h13F8; beats = 5'd4; rd_req = 1'b1;
        run("t3_done");
        rd_req = 1'b0;
        tick();
        chk("t3_beat1_seq", 32'(trans_log[1]), 32'(HTRANS_SEQ));
        chk("t3_beat2_nonseq", 32'(trans_log[2]), 32'(HTRANS_NONSEQ));
        chk("t3_beat2_addr", addr_log[2], 32'h1400);
        chk("t3_beat3_seq", 32'(trans_log[3]), 32'(HTRANS_SEQ));
        chk("t3_npush", 32'(n_push), 32'd4);

        // 8-beat write losing grant after beat 3 for 5 cycles
        clear_log();
        gnt_at = 2;
        wr_addr = 32'h3000; beats = 5'd8; wr_req = 1'b1;
        run("t4_done");
        wr_req = 1'b0;
        tick();
        chk("t4_beat3_seq", 32'(trans_log[2]), 32'(HTRANS_SEQ));
        chk("t4_resume_nonseq", 32'(trans_log[3]), 32'(HTRANS_NONSEQ));
        chk("t4_resume_addr", addr_log[3], 32'h300C);
        chk("t4_lastaddr", addr_log[7], 32'h301C);
        chk("t4_npop", 32'(n_pop), 32'd8);
        chk("t4_nwd", 32'(n_wd), 32'd8);
        chk("t4_nacc", 32'(n_acc), 32'd8);
        chk("t4_lastdata", wd_log[7], 32'hD000_0000 + rptr0 + 32'd7);

        // read with ERROR on beat 2
        clear_log();
        bad_beat = 2; bad_resp = HRESP_ERROR;
        rd_addr = 32'h4000; beats = 5'd4; rd_req = 1'b1;
        run("t5_done");
        rd_req = 1'b0;
        chk("t5_err_htrans", 32'(err_htrans), 32'(HTRANS_IDLE));
        chk("t5_npush", 32'(n_push), 32'd1);
        chk("t5_push0", push_log[0], 32'hA000_0001);
        chk("t5_nacc", 32'(n_acc), 32'd2);
        tick(); tick(); tick();
        chk("t5_xfer_err", 32'(xfer_err), 32'd1);
        chk("t5_one_done", 32'(n_done), 32'd1);

        // write with RETRY on beat 1: replayed word, no extra pop
        clear_log();
        bad_beat = 1; bad_resp = HRESP_RETRY;
        wr_addr = 32'h5000; beats = 5'd2; wr_req = 1'b1;
        tick(); tick();
        chk("t6_err_cleared", 32'(xfer_err), 32'd0);
        run("t6_done");
        wr_req = 1'b0;
        tick();
        chk("t6_npop", 32'(n_pop), 32'd2);
        chk("t6_nacc", 32'(n_acc), 32'd3);
        chk("t6_reissue_nonseq", 32'(trans_log[1]), 32'(HTRANS_NONSEQ));
        chk("t6_reissue_addr", addr_log[1], 32'h5000);
        chk("t6_nwd", 32'(n_wd), 32'd2);
        chk("t6_wd0", wd_log[0], 32'hD000_0000 + rptr0);
        chk("t6_wd1", wd_log[1], 32'hD000_0000 + rptr0 + 32'd1);

        // both requests: write first, then the held read
        clear_log();
        rd_addr = 32'h6000; wr_addr = 32'h7000; beats = 5'd2;
        rd_req = 1'b1; wr_req = 1'b1;
        run("t7_wr_done");
        wr_req = 1'b0;
        chk("t7_first_hwrite", 32'(hw_log[0]), 32'd1);
        chk("t7_first_addr", addr_log[0], 32'h7000);
        chk("t7_npop", 32'(n_pop), 32'd2);
        chk("t7_npush0", 32'(n_push), 32'd0);
        clear_log();
        run("t7_rd_done");
        rd_req = 1'b0;
        chk("t7_second_hwrite", 32'(hw_log[0]), 32'd0);
        chk("t7_second_addr", addr_log[0], 32'h6000);
        chk("t7_npush", 32'(n_push), 32'd2);
        tick();

        // asynchronous reset mid-burst
        clear_log();
        rd_addr = 32'h8000; beats = 5'd8; rd_req = 1'b1;
        for (int k = 0; k < 50 && n_acc < 3; k++) tick();
        chk("t8_started", 32'(n_acc >= 3), 32'd1);
        #2 hreset = 1'b1;
        #1;
        chk("t8_htrans", 32'(htrans), 32'(HTRANS_IDLE));
        chk("t8_hbusreq", 32'(hbusreq), 32'd0);
        chk("t8_haddr", haddr, 32'd0);
        chk("t8_fifo_wr", 32'(fifo_wr), 32'd0);
        chk("t8_req_done", 32'(req_done), 32'd0);
        chk("t8_hsize", 32'(hsize), 32'h2);
        chk("t8_hburst", 32'(hburst), 32'h1);
        rd_req = 1'b0;
        tick(); tick();
        hreset = 1'b0;
        dp_active = 1'b0; resp_stage = 0; hready = 1'b1; hresp = HRESP_OKAY;
        tick(); tick(); tick();
        chk("t8_no_done", 32'(n_done), 32'd0);
        chk("t8_idle_busreq", 32'(hbusreq), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
